// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_pkg
// Brief    : Shared constants and state type for the ALU command sequencer.
// Revision : 1.0
// ============================================================================
package ula_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [2:0] CODE_AND = 3'b000;
    localparam logic [2:0] CODE_OR  = 3'b001;
    localparam logic [2:0] CODE_ADD = 3'b010;
    localparam logic [2:0] CODE_SUB = 3'b011;
    localparam logic [2:0] CODE_SLT = 3'b100;
    localparam logic [2:0] CODE_NOR = 3'b101;
    localparam logic [2:0] CODE_MUL = 3'b110;
    localparam logic [2:0] CODE_RSV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic [3:0] code_to_op(input logic [2:0] code);
        case (code)
            CODE_OR:  return OP_OR;
            CODE_ADD: return OP_ADD;
            CODE_SUB: return OP_SUB;
            CODE_SLT: return OP_SLT;
            CODE_NOR: return OP_NOR;
            default:  return OP_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencer_if
// Brief    : Command, response and ALU-side signals of the ALU sequencer.
// Revision : 1.0
// ============================================================================
interface ula_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_code;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_data;
    logic                  rsp_cout;
    logic                  rsp_ovf;
    logic                  rsp_zero;
    logic                  rsp_err;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_cout;
    logic                  alu_overflow;
    logic                  alu_zero;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
        input  alu_result, alu_cout, alu_overflow, alu_zero,
        output cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_ovf, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_op
    );

    // Requester plus ALU side
    modport slave (
        output cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
        output alu_result, alu_cout, alu_overflow, alu_zero,
        input  cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_ovf, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_op
    );
endinterface
`default_nettype wire

// File: rtl/ula_mul_step.sv
`default_nettype none
// ============================================================================
// Module   : ula_mul_step
// Brief    : One shift-add multiply iteration: {P,Q} = {cout,result,Q} >> 1.
// Revision : 1.0
// ============================================================================
module ula_mul_step #(
    parameter int DATA_W = 8
) (
    input  wire logic [DATA_W-1:0] i_alu_result,
    input  wire logic              i_alu_cout,
    input  wire logic [DATA_W-1:0] i_q,
    output logic      [DATA_W-1:0] o_p_next,
    output logic      [DATA_W-1:0] o_q_next
);
    assign o_p_next = {i_alu_cout, i_alu_result[DATA_W-1:1]};
    assign o_q_next = {i_alu_result[0], i_q[DATA_W-1:1]};
endmodule
`default_nettype wire

// File: rtl/ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencer
// Brief    : Valid/ready command front-end for the 8-bit ALU with shift-add MUL.
// Revision : 1.0
// ============================================================================
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ENABLE_MUL = 1'b1
) (
    input wire logic        clk,
    input wire logic        rst,
    ula_sequencer_if.master bus
);
    localparam logic [2:0] c_CNT_LAST = 3'(DATA_W - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_code;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_p;
    logic [DATA_W-1:0]     r_q;
    logic [2:0]            r_cnt;
    logic [2*DATA_W-1:0]   r_rsp_data;
    logic                  r_rsp_cout;
    logic                  r_rsp_ovf;
    logic                  r_rsp_zero;
    logic                  r_rsp_err;

    logic [DATA_W-1:0]     w_alu_a;
    logic [DATA_W-1:0]     w_alu_b;
    logic [3:0]            w_alu_op;
    logic                  w_cmd_ready;
    logic                  w_rsp_valid;
    logic [DATA_W-1:0]     w_p_next;
    logic [DATA_W-1:0]     w_q_next;
    logic                  w_is_single;
    logic                  w_is_mul;

    assign w_is_single = (bus.cmd_code <= CODE_NOR);
    assign w_is_mul    = ENABLE_MUL && (bus.cmd_code == CODE_MUL);

    ula_mul_step #(.DATA_W(DATA_W)) u_mul_step (
        .i_alu_result (bus.alu_result),
        .i_alu_cout   (bus.alu_cout),
        .i_q          (r_q),
        .o_p_next     (w_p_next),
        .o_q_next     (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_op     = OP_AND;
        w_cmd_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (w_is_single)   w_state_next = ST_EXEC;
                    else if (w_is_mul) w_state_next = ST_MUL;
                    else               w_state_next = ST_RESP;
                end
            end
            ST_EXEC: begin
                w_alu_a      = r_a;
                w_alu_b      = r_q;
                w_alu_op     = code_to_op(r_code);
                w_state_next = ST_RESP;
            end
            ST_MUL: begin
                // Partial product accumulates in P; multiplier bits shift out of Q
                w_alu_a  = r_p;
                w_alu_b  = r_q[0] ? r_a : '0;
                w_alu_op = OP_ADD;
                if (r_cnt == c_CNT_LAST) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code     <= '0;
            r_a        <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_code <= bus.cmd_code;
                        r_a    <= bus.cmd_a;
                        r_q    <= bus.cmd_b;
                        r_p    <= '0;
                        r_cnt  <= '0;
                        if (!w_is_single && !w_is_mul) begin
                            r_rsp_data <= '0;
                            r_rsp_cout <= 1'b0;
                            r_rsp_ovf  <= 1'b0;
                            r_rsp_zero <= 1'b0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rsp_data <= {{DATA_W{1'b0}}, bus.alu_result};
                    r_rsp_cout <= bus.alu_cout;
                    r_rsp_ovf  <= bus.alu_overflow;
                    r_rsp_zero <= bus.alu_zero;
                    r_rsp_err  <= 1'b0;
                end
                ST_MUL: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_rsp_data <= {w_p_next, w_q_next};
                        r_rsp_cout <= 1'b0;
                        r_rsp_ovf  <= |w_p_next;
                        r_rsp_zero <= ~|{w_p_next, w_q_next};
                        r_rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_op    = w_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_sequencer
// Brief    : Self-checking bench: ALU model, directed cases and random traffic.
// Revision : 1.0
// ============================================================================
module tb_ula_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    ula_sequencer_if bus ();
    ula_sequencer_if bus_nm ();

    ula_sequencer #(.DATA_W(8), .ENABLE_MUL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ula_sequencer #(.DATA_W(8), .ENABLE_MUL(1'b0)) dut_nm (
        .clk (clk),
        .rst (rst),
        .bus (bus_nm)
    );

    // Combinational ALU: op = {ainvert, binvert/cin, sel}; logic ops report no carry/overflow
    function automatic logic [9:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        logic [7:0] aa, bb, r;
        logic [8:0] s;
        logic       c, v;
        aa = op[3] ? ~a : a;
        bb = op[2] ? ~b : b;
        s  = {1'b0, aa} + {1'b0, bb} + {8'b0, op[2]};
        v  = (aa[7] == bb[7]) && (s[7] != aa[7]);
        c  = 1'b0;
        case (op[1:0])
            2'b00: begin r = aa & bb; v = 1'b0; end
            2'b01: begin r = aa | bb; v = 1'b0; end
            2'b10: begin r = s[7:0]; c = s[8]; end
            default: begin r = {7'b0, s[7] ^ v}; c = s[8]; end
        endcase
        return {c, v, r};
    endfunction

    logic [9:0] w_alu_m;
    assign w_alu_m          = alu_eval(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_result   = w_alu_m[7:0];
    assign bus.alu_overflow = w_alu_m[8];
    assign bus.alu_cout     = w_alu_m[9];
    assign bus.alu_zero     = (w_alu_m[7:0] == 8'h00);

    assign bus_nm.alu_result   = 8'h00;
    assign bus_nm.alu_overflow = 1'b0;
    assign bus_nm.alu_cout     = 1'b0;
    assign bus_nm.alu_zero     = 1'b1;

    typedef struct {
        logic [15:0] data;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
        logic [3:0]  op;
    } exp_t;

    // Reference: plain arithmetic on the command fields
    function automatic exp_t ref_model(input logic [2:0] code, input logic [7:0] a,
                                       input logic [7:0] b);
        exp_t e;
        int   sa, sb, ua, ub;
        sa = $signed(a); sb = $signed(b);
        ua = int'(a);    ub = int'(b);
        e.data = 16'h0; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 2;
        case (code)
            3'd0: begin e.data = {8'h0, a & b};    e.op = 4'b0000; end
            3'd1: begin e.data = {8'h0, a | b};    e.op = 4'b0001; end
            3'd2: begin
                e.data = 16'((ua + ub) & 255); e.cout = (ua + ub) > 255;
                e.ovf  = (sa + sb) > 127 || (sa + sb) < -128; e.op = 4'b0010;
            end
            3'd3: begin
                e.data = 16'((ua - ub) & 255); e.cout = ua >= ub;
                e.ovf  = (sa - sb) > 127 || (sa - sb) < -128; e.op = 4'b0110;
            end
            3'd4: begin
                e.data = (sa < sb) ? 16'd1 : 16'd0; e.cout = ua >= ub;
                e.ovf  = (sa - sb) > 127 || (sa - sb) < -128; e.op = 4'b0111;
            end
            3'd5: begin e.data = {8'h0, ~(a | b)}; e.op = 4'b1100; end
            3'd6: begin
                e.data = 16'(ua * ub); e.ovf = (ua * ub) > 255; e.lat = 9; e.op = 4'b0010;
            end
            default: begin e.err = 1'b1; e.lat = 1; e.op = 4'b0000; end
        endcase
        e.zero = !e.err && (e.data == 16'h0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input exp_t e);
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(e.data));
        check({tag, "_flags"}, {28'h0, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero, bus.rsp_err},
              {28'h0, e.cout, e.ovf, e.zero, e.err});
    endtask

    // Called and returning on a negedge
    task automatic run_op(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b,
                          input int hold);
        exp_t e;
        int   lat;
        e = ref_model(code, a, b);
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_code = code; bus.cmd_a = a; bus.cmd_b = b;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0; bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
            check("busy_ready", 32'(bus.cmd_ready), 32'd0);
            if (code == 3'd6 || lat == 1) check("busy_alu_op", 32'(bus.alu_op), 32'(e.op));
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(e.lat));
        check_rsp("rsp", e);
        check("resp_quiet", {bus.cmd_ready, bus.alu_op, bus.alu_a, bus.alu_b}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, bus.rsp_valid}, 32'd1);
            check_rsp("hold", e);
            check("hold_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("post_handshake", {30'h0, bus.cmd_ready, bus.rsp_valid}, 32'b10);
    endtask

    int  seen;
    logic [2:0] r_code;

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_code = 3'd0; bus.cmd_a = 8'h0; bus.cmd_b = 8'h0;
        bus.rsp_ready = 1'b0;
        bus_nm.cmd_valid = 1'b0; bus_nm.cmd_code = 3'd0; bus_nm.cmd_a = 8'h0;
        bus_nm.cmd_b = 8'h0; bus_nm.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {bus.cmd_ready, bus.rsp_valid, bus.alu_op, bus.rsp_cout,
              bus.rsp_ovf, bus.rsp_zero, bus.rsp_err}, 32'b1_0_0000_0000);
        check("reset_data", 32'(bus.rsp_data), 32'h0);

        run_op(3'd2, 8'h7F, 8'h01, 0);
        run_op(3'd3, 8'h05, 8'h05, 0);
        run_op(3'd4, 8'h03, 8'h09, 0);
        run_op(3'd6, 8'hFF, 8'hFF, 0);
        run_op(3'd6, 8'h00, 8'h37, 0);
        run_op(3'd6, 8'h0C, 8'h0A, 0);
        run_op(3'd1, 8'hA5, 8'h3C, 5);
        run_op(3'd7, 8'h12, 8'h34, 1);

        // Reset asserted in the 4th MUL cycle aborts without a response
        bus.cmd_valid = 1'b1; bus.cmd_code = 3'd6; bus.cmd_a = 8'h9D; bus.cmd_b = 8'hE3;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {bus.cmd_ready, bus.rsp_valid, bus.alu_op}, 32'b1_0_0000);
        check("abort_data", 32'(bus.rsp_data), 32'h0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);

        // MUL code with multiply disabled behaves as reserved
        bus_nm.cmd_valid = 1'b1; bus_nm.cmd_code = 3'd6;
        bus_nm.cmd_a = 8'h11; bus_nm.cmd_b = 8'h22;
        @(posedge clk);
        #1;
        bus_nm.cmd_valid = 1'b0;
        @(negedge clk);
        check("nm_rsp", {bus_nm.rsp_valid, bus_nm.rsp_err, bus_nm.rsp_cout, bus_nm.rsp_ovf,
              bus_nm.rsp_zero, bus_nm.alu_op}, 32'b1_1_000_0000);
        check("nm_data", 32'(bus_nm.rsp_data), 32'h0);
        bus_nm.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_nm.rsp_ready = 1'b0;
        @(negedge clk);
        check("nm_idle", {bus_nm.cmd_ready, bus_nm.rsp_valid}, 32'b10);

        for (int n = 0; n < 80; n++) begin
            r_code = 3'($urandom_range(0, 7));
            run_op(r_code, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
Command-side controller (initiator) for the team's 8-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's a/b/op inputs. It samples the ALU's result/cout/overflow/zero and returns a registered response over a second valid/ready handshake. It also runs unsigned 8x8 multiply by iterating ALU additions (shift-add, 8 cycles).

Parameters:
DATA_W, 8, operand width; must equal the ALU width; only 8 supported.
ENABLE_MUL, 1, when 0 the MUL code is treated as reserved.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  request valid
cmd_ready  out  1  request accepted when valid&ready
cmd_code  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 reserved
cmd_a  in  8  operand A (multiplicand for MUL)
cmd_b  in  8  operand B (multiplier for MUL)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  16  result; single ops zero-extended, MUL full product
rsp_cout  out  1  ALU carry-out (MUL: 0)
rsp_ovf  out  1  ALU overflow (MUL: product[15:8]!=0)
rsp_zero  out  1  rsp_data==0
rsp_err  out  1  reserved/disabled code
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_op  out  4  to ALU op {ainvert, binvert/cin, sel[1:0]}
alu_result  in  8  from ALU
alu_cout  in  1  from ALU
alu_overflow  in  1  from ALU
alu_zero  in  1  from ALU

Behaviour:
- Reset: state IDLE; cmd_ready=1 on the following cycle; rsp_valid=0; rsp_data=0; all rsp flags=0; iteration count=0.
- ALU op map: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- ALU is combinational; outputs are sampled in the same cycle the inputs are driven.
- States: IDLE, EXEC, MUL, RESP.
- IDLE: cmd_ready=1. On accept, latch code/a/b.
  - Single op -> EXEC.
  - MUL (ENABLE_MUL=1) -> MUL with P=0, Q=cmd_b, M=cmd_a, cnt=0.
  - Reserved -> RESP with data=0, err=1, other flags=0.
- EXEC (1 cycle): drive alu_a/alu_b/alu_op from latches. Capture {8'h00,alu_result}, alu_cout, alu_overflow and zero into rsp regs. -> RESP.
- MUL (8 cycles):
  - Drive alu_op=ADD, alu_a=P, alu_b = Q[0] ? M : 0.
  - Each cycle: {P,Q} <= {alu_cout, alu_result, Q} >> 1; cnt++.
  - When cnt==7, capture product {P,Q} (post-shift) -> RESP.
- RESP: rsp_valid=1. rsp_* held stable until rsp_ready. On handshake -> IDLE.
- cmd_ready=0 in EXEC/MUL/RESP; no command overlap.
- Latency, counted from the accept edge to the first cycle rsp_valid=1: single op 2, MUL 9, reserved 1. Max throughput is one single op per 3 cycles.
- Outside EXEC/MUL: alu_a=0, alu_b=0, alu_op=0000 (deterministic, no toggling).
- rst during any state, including mid-MUL: abort without a response; reset values apply next cycle. rst has priority over all handshakes.
- MUL is unsigned. rsp_ovf flags a product that does not fit in 8 bits.

Decomposition:
- Shared package ula_pkg:
  - ALU op constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR).
  - cmd_code constants.
  - state encoding.
- One natural sub-module: ula_mul_step, a pure combinational block computing the next {P,Q} from alu_result, alu_cout and the current Q.
- Everything else stays in ula_sequencer.

Test Plan:
1. ADD a=0x7F b=0x01 -> rsp_data=0x0080, ovf=1, cout=0, zero=0; rsp_valid exactly 2 cycles after accept; alu_op=0010 during EXEC.
2. SUB a=0x05 b=0x05 -> rsp_data=0x0000, zero=1, cout=1, ovf=0. SLT a=0x03 b=0x09 -> rsp_data=0x0001.
3. MUL 0xFF*0xFF -> 0xFE01, ovf=1, cout=0, at 9 cycles. MUL 0x00*0x37 -> 0x0000, zero=1. MUL 0x0C*0x0A -> 0x0078, ovf=0.
4. Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0 throughout; accept on cycle 6, then cmd_ready=1 next cycle.
5. Assert rst during the 4th MUL cycle -> next cycle IDLE, cmd_ready=1, rsp_valid=0, alu_op=0000; no response is ever emitted.
6. Code 111, or 110 with ENABLE_MUL=0 -> rsp_err=1, rsp_data=0, all flags 0, rsp_valid 1 cycle after accept; alu_op stays 0000.
